ysyx_24100006_pipe_ctrl: RTL

YSYX_24100006_PIPE_CTRL -- requirements
Module: ysyx_24100006_pipe_ctrl

---
 rtl/ysyx_24100006_pipe_pkg.sv | 20 ++
 rtl/ysyx_24100006_scoreboard.sv | 54 +++++
 rtl/ysyx_24100006_pipe_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ysyx_24100006_pipe_pkg.sv
// Shared types and widths for the pipeline hazard/flow controller.
package ysyx_24100006_pipe_pkg;

   localparam int GPR_AW   = 4;
   localparam int NUM_GPR  = 16;
   localparam int SB_CNT_W = 2;
   localparam int INFL_W   = 2;
   localparam int PERF_W   = 32;

   localparam logic [SB_CNT_W-1:0] SB_CNT_MAX = 2'd3;
   localparam logic [INFL_W-1:0]   INFL_MAX   = 2'd3;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_FLUSH = 2'd2,
      ST_HALT  = 2'd3
   } pipe_state_t;

endpackage

// File: rtl/ysyx_24100006_scoreboard.sv
// GPR write scoreboard: per-register count of in-flight writers (x1..x15).
module ysyx_24100006_scoreboard
   import ysyx_24100006_pipe_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              inc_valid,
   input  logic [GPR_AW-1:0] inc_addr,
   input  logic              dec_valid,
   input  logic [GPR_AW-1:0] dec_addr,
   input  logic [GPR_AW-1:0] rs1_addr,
   input  logic [GPR_AW-1:0] rs2_addr,
   input  logic [GPR_AW-1:0] rd_addr,
   output logic              rs1_busy,
   output logic              rs2_busy,
   output logic              rd_full,
   output logic              dec_err
);

   // entry 0 is a constant zero so lookups never need a range guard
   logic [NUM_GPR-1:0][SB_CNT_W-1:0] cnt;

   logic inc_act;
   logic dec_act;
   logic same_reg;

   assign inc_act  = inc_valid && (inc_addr != '0);
   assign dec_act  = dec_valid && (dec_addr != '0);
   assign same_reg = inc_act && dec_act && (inc_addr == dec_addr);

   assign rs1_busy = (rs1_addr != '0) && (cnt[rs1_addr] != '0);
   assign rs2_busy = (rs2_addr != '0) && (cnt[rs2_addr] != '0);
   assign rd_full  = (rd_addr  != '0) && (cnt[rd_addr] == SB_CNT_MAX);
   // underflow: a retirement with no writer recorded (and no matching issue)
   assign dec_err  = dec_act && !same_reg && (cnt[dec_addr] == '0);

   // count update; simultaneous inc/dec on one register cancels, zero saturates
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else begin
         cnt[0] <= '0;
         for (int i = 1; i < NUM_GPR; i++) begin
            if (!same_reg) begin
               if (inc_act && (inc_addr == GPR_AW'(i)))
                  cnt[i] <= cnt[i] + 1'b1;
               else if (dec_act && (dec_addr == GPR_AW'(i)) && (cnt[i] != '0))
                  cnt[i] <= cnt[i] - 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ysyx_24100006_pipe_ctrl.sv
// Pipeline flow controller: RAW scoreboard stall, serialisation drain,
// one-cycle redirect flush and ebreak halt.
// Optional perf counters enabled by defining YSYX_24100006_PIPE_PERF_EN.
module ysyx_24100006_pipe_ctrl
   import ysyx_24100006_pipe_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid_i,
   input  logic [GPR_AW-1:0] id_rs1_addr_i,
   input  logic [GPR_AW-1:0] id_rs2_addr_i,
   input  logic [GPR_AW-1:0] id_rd_addr_i,
   input  logic              id_rs1_used_i,
   input  logic              id_rs2_used_i,
   input  logic              id_gpr_write_i,
   input  logic              id_serial_i,
   input  logic              ex_in_ready_i,
   input  logic              redirect_valid_i,
   input  logic [31:0]       redirect_pc_i,
   input  logic              wb_valid_i,
   input  logic              wb_gpr_write_i,
   input  logic              wb_is_break_i,
   input  logic [GPR_AW-1:0] wb_rd_addr_i,
   output logic              id_ready_o,
   output logic              issue_o,
   output logic              flush_if_id_o,
   output logic              ifu_redirect_valid_o,
   output logic              halt_o,
   output logic              sb_err_o,
   output logic [31:0]       ifu_redirect_pc_o,
   output logic [1:0]        state_o,
   output logic [PERF_W-1:0] perf_raw_stall_o,
   output logic [PERF_W-1:0] perf_flush_o
);

   pipe_state_t       state, state_nxt;
   logic [INFL_W-1:0] inflight;
   logic              pc_capture;
   logic              rs1_busy, rs2_busy, rd_full, sb_dec_err;
   logic              raw_stall, serial_block, infl_err;

   ysyx_24100006_scoreboard u_sb (
      .clk       (clk),
      .reset     (reset),
      .inc_valid (issue_o && id_gpr_write_i),
      .inc_addr  (id_rd_addr_i),
      .dec_valid (wb_valid_i && wb_gpr_write_i),
      .dec_addr  (wb_rd_addr_i),
      .rs1_addr  (id_rs1_addr_i),
      .rs2_addr  (id_rs2_addr_i),
      .rd_addr   (id_rd_addr_i),
      .rs1_busy  (rs1_busy),
      .rs2_busy  (rs2_busy),
      .rd_full   (rd_full),
      .dec_err   (sb_dec_err)
   );

   assign raw_stall    = id_valid_i && ((id_rs1_used_i && rs1_busy) ||
                                        (id_rs2_used_i && rs2_busy) ||
                                        (id_gpr_write_i && rd_full));
   assign serial_block = id_serial_i && (inflight != '0);
   // reset gating keeps the combinational handshake quiet while reset is held
   assign issue_o      = id_valid_i && ex_in_ready_i && !raw_stall && !redirect_valid_i &&
                         (state == ST_RUN) && !serial_block && (inflight != INFL_MAX) && !reset;
   assign id_ready_o   = issue_o;
   assign infl_err     = wb_valid_i && !issue_o && (inflight == '0);

   assign state_o              = state;
   assign flush_if_id_o        = (state == ST_FLUSH);
   assign ifu_redirect_valid_o = (state == ST_FLUSH);
   assign halt_o               = (state == ST_HALT);

   // next-state: break retirement wins over everything, redirect only from RUN/DRAIN
   always_comb begin
      state_nxt  = state;
      pc_capture = 1'b0;
      if (wb_valid_i && wb_is_break_i) begin
         state_nxt = ST_HALT;
      end else begin
         case (state)
            ST_RUN: begin
               if (redirect_valid_i) begin
                  state_nxt  = ST_FLUSH;
                  pc_capture = 1'b1;
               end else if (id_valid_i && id_serial_i && (inflight != '0)) begin
                  state_nxt = ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (redirect_valid_i) begin
                  state_nxt  = ST_FLUSH;
                  pc_capture = 1'b1;
               end else if (inflight == '0) begin
                  state_nxt = ST_RUN;
               end
            end
            ST_FLUSH: state_nxt = ST_RUN;
            ST_HALT:  state_nxt = ST_HALT;
            default:  state_nxt = ST_RUN;
         endcase
      end
   end

   // state register and captured redirect target
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state             <= ST_RUN;
         ifu_redirect_pc_o <= '0;
      end else begin
         state <= state_nxt;
         if (pc_capture) ifu_redirect_pc_o <= redirect_pc_i;
      end
   end

   // in-flight instruction count; retirements tracked in every state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight <= '0;
      end else begin
         case ({issue_o, wb_valid_i})
            2'b10:   inflight <= inflight + 1'b1;
            2'b01:   if (inflight != '0) inflight <= inflight - 1'b1;
            default: inflight <= inflight;
         endcase
      end
   end

   // sticky underflow flag from either counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                       sb_err_o <= 1'b0;
      else if (sb_dec_err || infl_err) sb_err_o <= 1'b1;
   end

`ifdef YSYX_24100006_PIPE_PERF_EN
   // wrapping counters: RAW-stalled ID cycles and FLUSH entries
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_raw_stall_o <= '0;
         perf_flush_o     <= '0;
      end else begin
         if (raw_stall) perf_raw_stall_o <= perf_raw_stall_o + 1'b1;
         if (pc_capture && (state_nxt == ST_FLUSH)) perf_flush_o <= perf_flush_o + 1'b1;
      end
   end
`else
   assign perf_raw_stall_o = '0;
   assign perf_flush_o     = '0;
`endif

endmodule
